data_sram_bridge: RTL and testbench

- Sits directly downstream of the mips core's data port, between the memory-stage outputs (memenM, byte-select memwrite, aluoutM, writedata) and the SoC data bus.
- Converts the core's single-cycle data request into a split address/data handshake bus transaction, with optional kseg0/kseg1 address translation.
- Drives a stall back to the pipeline until the bus transaction completes.
- Returns read data as a full 32-bit word; the existing byte/half select logic in the core extracts the needed bytes.

---
 rtl/data_sram_bridge.sv | 133 +++++++++++++
 tb/tb_data_sram_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns the core's single-cycle data-port request into a
// split address/data handshake on the SoC bus, with optional kseg0/kseg1
// translation. The pipeline is stalled until the bus transaction completes,
// then released for exactly one cycle (DONE) in which cpu_rdata is valid.
module data_sram_bridge #(
  parameter int MAP_KSEG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_capture;
  logic        w_launch;
  logic [3:0]  w_size_lo;

  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map onto physical low memory by
  // dropping the top three bits; everything else is passed through.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if ((MAP_KSEG != 0) && (a[31:30] == 2'b10))
      return {3'b000, a[28:0]};
    return a;
  endfunction

  // Byte-enable pattern -> {bus size, low address bits}. Reads and any
  // pattern the core never produces fall back to an aligned word access.
  function automatic logic [3:0] decode_wen(input logic [3:0] wen);
    case (wen)
      4'b0001: return {2'd0, 2'd0};
      4'b0010: return {2'd0, 2'd1};
      4'b0100: return {2'd0, 2'd2};
      4'b1000: return {2'd0, 2'd3};
      4'b0011: return {2'd1, 2'd0};
      4'b1100: return {2'd1, 2'd2};
      default: return {2'd2, 2'd0};
    endcase
  endfunction

  assign w_size_lo = decode_wen(cpu_wen);
  assign w_launch  = (r_state == IDLE) && cpu_en;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; w_capture marks the cycle the slave delivers data.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_en) w_next = ADDR;
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            w_next    = DONE;
            w_capture = 1'b1;
          end else begin
            w_next = DATA;
          end
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          w_next    = DONE;
          w_capture = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request latch on launch from IDLE; read data capture on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_launch) begin
        r_wr    <= |cpu_wen;
        r_size  <= w_size_lo[3:2];
        r_addr  <= (map_addr(cpu_addr) & 32'hFFFF_FFFC) | {30'd0, w_size_lo[1:0]};
        r_wdata <= cpu_wdata;
      end
      if (w_capture && !r_wr) r_rdata <= bus_rdata;
    end
  end

  // The address phase is exactly the ADDR state, so the request is a decode
  // of the state register and drops on the edge that accepts the address.
  assign bus_req   = (r_state == ADDR);
  assign bus_wr    = r_wr;
  assign bus_size  = r_size;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign cpu_rdata = r_rdata;
  assign cpu_stall = cpu_en && (r_state != DONE);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Testbench for data_sram_bridge: one translating and one non-translating
// instance share the same stimulus and slave; expected bus transactions,
// stall lengths and returned read words are queued when a request is issued
// and compared when the bridge presents them.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = 4'd0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  logic [31:0] cpu_rdata0, cpu_rdata1;
  logic        cpu_stall0, cpu_stall1;
  logic        bus_req0, bus_req1, bus_wr0, bus_wr1;
  logic [1:0]  bus_size0, bus_size1;
  logic [31:0] bus_addr0, bus_addr1, bus_wdata0, bus_wdata1;

  data_sram_bridge #(.MAP_KSEG(1)) u_map (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0),
    .cpu_stall(cpu_stall0), .bus_req(bus_req0), .bus_wr(bus_wr0),
    .bus_size(bus_size0), .bus_addr(bus_addr0), .bus_wdata(bus_wdata0),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  data_sram_bridge #(.MAP_KSEG(0)) u_nomap (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata1),
    .cpu_stall(cpu_stall1), .bus_req(bus_req1), .bus_wr(bus_wr1),
    .bus_size(bus_size1), .bus_addr(bus_addr1), .bus_wdata(bus_wdata1),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] addr_nm;
    logic [31:0] wdata;
  } txn_t;

  txn_t        q_txn[$];
  int          q_stall[$];
  logic [31:0] q_rdata[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_cnt = 0;
  logic [31:0] m_rdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Spec table: byte enables -> {size, addr[1:0]}.
  function automatic logic [3:0] exp_size_lo(input logic [3:0] wen);
    case (wen)
      4'b0001: return 4'b00_00;
      4'b0010: return 4'b00_01;
      4'b0100: return 4'b00_10;
      4'b1000: return 4'b00_11;
      4'b0011: return 4'b01_00;
      4'b1100: return 4'b01_10;
      default: return 4'b10_00;
    endcase
  endfunction

  function automatic logic [31:0] exp_map(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  // One complete access. aw = ADDR cycles with addr_ok low before
  // acceptance; dw = cycles from acceptance to data_ok (0 = same cycle).
  task automatic access(input logic [31:0] a, input logic [3:0] wen,
                        input logic [31:0] wd, input int aw, input int dw,
                        input logic [31:0] rd);
    txn_t t;
    logic [3:0] sl;
    sl        = exp_size_lo(wen);
    t.wr      = |wen;
    t.size    = sl[3:2];
    t.addr    = (exp_map(a) & 32'hFFFF_FFFC) | {30'd0, sl[1:0]};
    t.addr_nm = (a & 32'hFFFF_FFFC) | {30'd0, sl[1:0]};
    t.wdata   = wd;
    q_txn.push_back(t);
    q_stall.push_back(2 + aw + dw);
    if (wen == 4'd0) m_rdata = rd;
    q_rdata.push_back(m_rdata);
    // IDLE: present the request
    cpu_en = 1'b1; cpu_addr = a; cpu_wen = wen; cpu_wdata = wd;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    @(posedge clk); #1;
    // ADDR: core inputs wander, stray data_ok must be ignored
    for (int i = 0; i < aw; i++) begin
      cpu_addr = $urandom; cpu_wen = 4'($urandom_range(15)); cpu_wdata = $urandom;
      bus_addr_ok = 1'b0; bus_data_ok = (i == 0); bus_rdata = $urandom;
      @(posedge clk); #1;
    end
    cpu_addr = $urandom; cpu_wen = 4'($urandom_range(15)); cpu_wdata = $urandom;
    bus_addr_ok = 1'b1; bus_data_ok = (dw == 0);
    bus_rdata = (dw == 0) ? rd : 32'($urandom);
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    for (int i = 1; i <= dw; i++) begin
      bus_data_ok = (i == dw);
      bus_rdata = (i == dw) ? rd : 32'($urandom);
      @(posedge clk); #1;
    end
    // DONE
    bus_data_ok = 1'b0; bus_rdata = $urandom;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cpu_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_req", {31'd0, bus_req0}, 32'd0);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else begin
      if (bus_req0) begin
        if (q_txn.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("bus_wr",     {31'd0, bus_wr0},  {31'd0, q_txn[0].wr});
          chk("bus_size",   {30'd0, bus_size0}, {30'd0, q_txn[0].size});
          chk("bus_addr",   bus_addr0,  q_txn[0].addr);
          chk("bus_wdata",  bus_wdata0, q_txn[0].wdata);
          chk("nomap_req",  {31'd0, bus_req1}, 32'd1);
          chk("nomap_addr", bus_addr1, q_txn[0].addr_nm);
          chk("nomap_size", {30'd0, bus_size1}, {30'd0, q_txn[0].size});
          chk("nomap_wr",   {31'd0, bus_wr1}, {31'd0, q_txn[0].wr});
          chk("nomap_wdata", bus_wdata1, q_txn[0].wdata);
          if (bus_addr_ok) void'(q_txn.pop_front());
        end
      end
      if (cpu_en && cpu_stall0) stall_cnt++;
      if (cpu_en && !cpu_stall0) begin
        if (q_stall.size() == 0 || q_rdata.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("stall_cycles", stall_cnt, q_stall.pop_front());
          chk("cpu_rdata", cpu_rdata0, q_rdata[0]);
          chk("nomap_rdata", cpu_rdata1, q_rdata.pop_front());
          chk("nomap_stall", {31'd0, cpu_stall1}, 32'd0);
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req",   {31'd0, bus_req0}, 32'd0);
    chk("rst_wr",    {31'd0, bus_wr0},  32'd0);
    chk("rst_size",  {30'd0, bus_size0}, 32'd0);
    chk("rst_addr",  bus_addr0,  32'd0);
    chk("rst_wdata", bus_wdata0, 32'd0);
    chk("rst_rdata", cpu_rdata0, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall0}, 32'd0);
    idle(3);

    // zero-wait kseg1 read
    access(32'hBFC0_0004, 4'b0000, 32'h0, 0, 0, 32'h1234_5678);
    idle(1);
    // byte write, data three cycles after address acceptance
    access(32'h8000_0013, 4'b1000, 32'hAA00_0000, 0, 3, 32'hDEAD_BEEF);
    idle(1);
    // address phase held off for five cycles
    access(32'h0000_1000, 4'b1111, 32'hCAFE_F00D, 5, 1, 32'h0);
    idle(1);
    // halfword write: translated vs untranslated instance
    access(32'h8000_0102, 4'b1100, 32'h5566_0000, 0, 0, 32'h0);
    idle(2);
    // back-to-back reads, cpu_en held high across both
    access(32'h0000_0040, 4'b0000, 32'h0, 0, 0, 32'h0BAD_F00D);
    access(32'hA000_0080, 4'b0000, 32'h0, 1, 2, 32'h7777_1111);
    idle(1);

    // remaining byte-enable patterns, including an illegal one
    begin
      logic [3:0] wl [5];
      wl[0] = 4'b0001; wl[1] = 4'b0010; wl[2] = 4'b0100;
      wl[3] = 4'b0011; wl[4] = 4'b0101;
      for (int k = 0; k < 5; k++) begin
        access($urandom, wl[k], $urandom, k % 2, k % 3, 32'h0);
        idle(1);
      end
    end

    // reset while waiting in DATA
    q_txn.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h0000_0200,
                      addr_nm: 32'h8000_0200, wdata: 32'h0});
    cpu_en = 1'b1; cpu_addr = 32'h8000_0200; cpu_wen = 4'd0; cpu_wdata = 32'h0;
    @(posedge clk); #1;
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0; rst = 1'b1; cpu_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_req",   {31'd0, bus_req0}, 32'd0);
    chk("mid_rst_rdata", cpu_rdata0, 32'd0);
    chk("mid_rst_addr",  bus_addr0, 32'd0);
    chk("mid_rst_size",  {30'd0, bus_size0}, 32'd0);
    chk("mid_rst_stall", {31'd0, cpu_stall0}, 32'd0);
    chk("mid_rst_txn_q", q_txn.size(), 32'd0);
    q_stall.delete();
    q_rdata.delete();
    m_rdata = 32'd0;
    idle(1);
    access(32'h0000_0300, 4'b0000, 32'h0, 1, 1, 32'h4242_4242);
    idle(1);

    // random mix of reads and writes
    for (int k = 0; k < 8; k++) begin
      logic [3:0] w;
      w = (k % 2 == 0) ? 4'b0000 : 4'($urandom_range(15));
      access($urandom, w, $urandom, int'($urandom_range(3)),
             int'($urandom_range(3)), $urandom);
      if (k % 3 == 0) idle(1);
    end
    idle(3);

    chk("txn_q_empty",   q_txn.size(),   32'd0);
    chk("stall_q_empty", q_stall.size(), 32'd0);
    chk("rdata_q_empty", q_rdata.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
